// File: rtl/cpu_addr_seq.sv
// cpu_addr_seq: sequences the shared 8-bit ALU through the low and high bytes
// of a 16-bit address operation (INC16, ADD_IDX, REL, DEC16).
// The result is registered and held. page_cross reports whether the high byte
// needed a fix-up. With FAST_NOFIX=1 the HI cycle is skipped when no fix-up is
// needed.
module cpu_addr_seq #(
    parameter bit FAST_NOFIX = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] base,
    input  logic [7:0]  offset,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        page_cross,
    output logic        alu_add,
    output logic        alu_inc_B,
    output logic        alu_dec_B,
    output logic        alu_pass_B,
    output logic        alu_carry_in,
    output logic [7:0]  alu_A,
    output logic [7:0]  alu_B,
    input  logic [7:0]  alu_out,
    input  logic        alu_carry_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FIX_NONE = 2'd0,
        FIX_INC  = 2'd1,
        FIX_DEC  = 2'd2
    } fix_t;

    localparam logic [1:0] OP_INC16   = 2'b00;
    localparam logic [1:0] OP_ADD_IDX = 2'b01;
    localparam logic [1:0] OP_REL     = 2'b10;
    localparam logic [1:0] OP_DEC16   = 2'b11;

    state_t      state;
    state_t      state_next;
    fix_t        fix_q;
    fix_t        lo_fix;
    logic [1:0]  op_q;
    logic [15:0] base_q;
    logic [7:0]  offset_q;
    logic [7:0]  lo_q;
    logic [15:0] result_q;
    logic        page_cross_q;
    logic        accept;
    logic        fast_skip;

    assign busy       = (state == ST_LO) || (state == ST_HI);
    assign done       = (state == ST_DONE);
    assign result     = result_q;
    assign page_cross = page_cross_q;

    // Decide the high-byte fix-up from the low-byte carry (carry clear on a
    // decrement means a borrow). A REL offset's sign selects which direction
    // of carry needs fixing.
    always_comb begin
        lo_fix = FIX_NONE;
        case (op_q)
            OP_INC16, OP_ADD_IDX: begin
                if (alu_carry_out) lo_fix = FIX_INC;
            end
            OP_DEC16: begin
                if (!alu_carry_out) lo_fix = FIX_DEC;
            end
            OP_REL: begin
                if (!offset_q[7] && alu_carry_out) begin
                    lo_fix = FIX_INC;
                end else if (offset_q[7] && !alu_carry_out) begin
                    lo_fix = FIX_DEC;
                end
            end
            default: lo_fix = FIX_NONE;
        endcase
    end

    assign fast_skip = FAST_NOFIX && (lo_fix == FIX_NONE);

    // Next-state logic plus ALU control. The ALU is only driven in LO and HI,
    // and every ALU output is zero otherwise.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        alu_add      = 1'b0;
        alu_inc_B    = 1'b0;
        alu_dec_B    = 1'b0;
        alu_pass_B   = 1'b0;
        alu_carry_in = 1'b0;
        alu_A        = 8'h00;
        alu_B        = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_LO;
                end
            end
            ST_LO: begin
                alu_B = base_q[7:0];
                case (op_q)
                    OP_INC16: alu_inc_B = 1'b1;
                    OP_DEC16: alu_dec_B = 1'b1;
                    default: begin
                        alu_add      = 1'b1;
                        alu_A        = offset_q;
                        alu_carry_in = 1'b0;
                    end
                endcase
                state_next = fast_skip ? ST_DONE : ST_HI;
            end
            ST_HI: begin
                alu_B = base_q[15:8];
                case (fix_q)
                    FIX_INC: alu_inc_B  = 1'b1;
                    FIX_DEC: alu_dec_B  = 1'b1;
                    default: alu_pass_B = 1'b1;
                endcase
                state_next = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_LO;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, operand latch and byte-result capture. The result is
    // written only on entry to DONE, so it holds between operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_q         <= 2'b00;
            base_q       <= 16'h0000;
            offset_q     <= 8'h00;
            lo_q         <= 8'h00;
            fix_q        <= FIX_NONE;
            result_q     <= 16'h0000;
            page_cross_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q     <= op;
                base_q   <= base;
                offset_q <= offset;
            end
            if (state == ST_LO) begin
                lo_q  <= alu_out;
                fix_q <= lo_fix;
                if (fast_skip) begin
                    result_q     <= {base_q[15:8], alu_out};
                    page_cross_q <= 1'b0;
                end
            end
            if (state == ST_HI) begin
                result_q     <= {alu_out, lo_q};
                page_cross_q <= (fix_q != FIX_NONE);
            end
        end
    end

endmodule

// File: tb/tb_cpu_addr_seq.sv
// Testbench for cpu_addr_seq. It runs two instances (normal and fast path),
// each with its own behavioural 8-bit ALU. A scoreboard checks result,
// page_cross and done timing against 16-bit arithmetic.
module tb_cpu_addr_seq;

    localparam logic [1:0] OP_INC16   = 2'b00;
    localparam logic [1:0] OP_ADD_IDX = 2'b01;
    localparam logic [1:0] OP_REL     = 2'b10;
    localparam logic [1:0] OP_DEC16   = 2'b11;

    typedef struct {
        logic [15:0] res;
        logic        pc;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start_v = 2'b00;
    logic [1:0]  op = 2'b00;
    logic [15:0] base = 16'h0000;
    logic [7:0]  offset = 8'h00;

    logic        n_busy, n_done, n_pc, n_add, n_inc, n_dec, n_pass, n_cin, n_cout;
    logic [15:0] n_result;
    logic [7:0]  n_A, n_B, n_out;
    logic        f_busy, f_done, f_pc, f_add, f_inc, f_dec, f_pass, f_cin, f_cout;
    logic [15:0] f_result;
    logic [7:0]  f_A, f_B, f_out;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    // Free-running cycle counter used to time done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 8-bit ALU: {carry_out, out}. On a decrement, carry_out=1 means no borrow.
    function automatic logic [8:0] aluModel(input logic add, input logic inc, input logic dec,
                                            input logic pass, input logic cin,
                                            input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = 9'h000;
        if (add)       r = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        else if (inc)  r = {(b == 8'hFF), b + 8'h01};
        else if (dec)  r = {(b != 8'h00), b - 8'h01};
        else if (pass) r = {1'b0, b};
        return r;
    endfunction

    assign {n_cout, n_out} = aluModel(n_add, n_inc, n_dec, n_pass, n_cin, n_A, n_B);
    assign {f_cout, f_out} = aluModel(f_add, f_inc, f_dec, f_pass, f_cin, f_A, f_B);

    cpu_addr_seq #(.FAST_NOFIX(1'b0)) dut_norm (
        .clk(clk), .rst(rst), .start(start_v[0]), .op(op), .base(base), .offset(offset),
        .busy(n_busy), .done(n_done), .result(n_result), .page_cross(n_pc),
        .alu_add(n_add), .alu_inc_B(n_inc), .alu_dec_B(n_dec), .alu_pass_B(n_pass),
        .alu_carry_in(n_cin), .alu_A(n_A), .alu_B(n_B),
        .alu_out(n_out), .alu_carry_out(n_cout)
    );

    cpu_addr_seq #(.FAST_NOFIX(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .start(start_v[1]), .op(op), .base(base), .offset(offset),
        .busy(f_busy), .done(f_done), .result(f_result), .page_cross(f_pc),
        .alu_add(f_add), .alu_inc_B(f_inc), .alu_dec_B(f_dec), .alu_pass_B(f_pass),
        .alu_carry_in(f_cin), .alu_A(f_A), .alu_B(f_B),
        .alu_out(f_out), .alu_carry_out(f_cout)
    );

    // Reference model: plain 16-bit arithmetic. Returns {page_cross, result}.
    function automatic logic [16:0] refModel(input logic [1:0] o, input logic [15:0] b,
                                             input logic [7:0] off);
        logic [15:0] r;
        case (o)
            OP_INC16:   r = b + 16'd1;
            OP_ADD_IDX: r = b + {8'h00, off};
            OP_REL:     r = b + {{8{off[7]}}, off};
            default:    r = b - 16'd1;
        endcase
        return {(r[15:8] != b[15:8]), r};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Issue one operation to the instances selected by mask. Start stays high for one cycle.
    task automatic applyStimulus(input logic [1:0] mask, input logic [1:0] o,
                                 input logic [15:0] b, input logic [7:0] off);
        logic [16:0] m;
        exp_t        e;
        m      = refModel(o, b, off);
        op     = o;
        base   = b;
        offset = off;
        start_v = mask;
        e.res = m[15:0];
        e.pc  = m[16];
        if (mask[0]) begin
            e.due = cyc + 3;
            q0.push_back(e);
        end
        if (mask[1]) begin
            e.due = cyc + (m[16] ? 3 : 2);
            q1.push_back(e);
        end
        @(posedge clk); #1;
        start_v = 2'b00;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) checkOutput("drain_timeout", 32'(n), 32'd0);
    endtask

    task automatic nextCycle();
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor for one instance. It pops an expectation on each done and flags late or unexpected pulses.
    task automatic scoreDut(input int idx, input logic dn, input logic [15:0] res,
                            input logic pc, input logic [20:0] alu_bus);
        exp_t  e;
        int    sz;
        string tag;
        tag = (idx == 0) ? "norm" : "fast";
        sz  = (idx == 0) ? q0.size() : q1.size();
        if (dn) begin
            if (sz == 0) begin
                checkOutput({tag, "_unexpected_done"}, {31'd0, dn}, 32'd0);
            end else begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                checkOutput({tag, "_result"}, {16'd0, res}, {16'd0, e.res});
                checkOutput({tag, "_page_cross"}, {31'd0, pc}, {31'd0, e.pc});
                checkOutput({tag, "_done_cycle"}, cyc, e.due);
                checkOutput({tag, "_alu_idle_in_done"}, {11'd0, alu_bus}, 32'd0);
            end
        end else if (sz != 0) begin
            if (idx == 0) e = q0[0];
            else          e = q1[0];
            if (cyc > e.due) begin
                checkOutput({tag, "_missing_done"}, {31'd0, dn}, 32'd1);
                if (idx == 0) void'(q0.pop_front());
                else          void'(q1.pop_front());
            end
        end
    endtask

    // Sample both instances on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            scoreDut(0, n_done, n_result, n_pc, {n_add, n_inc, n_dec, n_pass, n_cin, n_A, n_B});
            scoreDut(1, f_done, f_result, f_pc, {f_add, f_inc, f_dec, f_pass, f_cin, f_A, f_B});
        end
    end

    // Hard stop guard in case the stimulus thread ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence: directed cases first, then randomized operations.
    initial begin
        logic [15:0] rb;
        logic [1:0]  ro;
        logic [7:0]  rf;
        repeat (3) nextCycle();
        checkOutput("reset_busy", {30'd0, n_busy, f_busy}, 32'd0);
        checkOutput("reset_done", {30'd0, n_done, f_done}, 32'd0);
        checkOutput("reset_result", {n_result, f_result}, 32'd0);
        checkOutput("reset_pc", {30'd0, n_pc, f_pc}, 32'd0);
        checkOutput("reset_alu_norm", {11'd0, n_add, n_inc, n_dec, n_pass, n_cin, n_A, n_B}, 32'd0);
        rst = 1'b0;
        nextCycle();

        // ADD_IDX crossing a page. The LO and HI controls are checked directly.
        applyStimulus(2'b01, OP_ADD_IDX, 16'h12F0, 8'h20);
        checkOutput("lo_busy", {31'd0, n_busy}, 32'd1);
        checkOutput("lo_add_ctl", {27'd0, n_add, n_inc, n_dec, n_pass, n_cin}, 32'b10000);
        checkOutput("lo_A", {24'd0, n_A}, 32'h20);
        checkOutput("lo_B", {24'd0, n_B}, 32'hF0);
        nextCycle();
        checkOutput("hi_inc_ctl", {27'd0, n_add, n_inc, n_dec, n_pass, n_cin}, 32'b01000);
        checkOutput("hi_B", {24'd0, n_B}, 32'h12);
        waitIdle();

        applyStimulus(2'b11, OP_INC16, 16'hFFFF, 8'h00);
        waitIdle();
        applyStimulus(2'b11, OP_DEC16, 16'h0000, 8'h00);
        waitIdle();
        applyStimulus(2'b01, OP_DEC16, 16'h1234, 8'h77);
        nextCycle();
        checkOutput("dec_hi_pass_ctl", {27'd0, n_add, n_inc, n_dec, n_pass, n_cin}, 32'b00010);
        checkOutput("dec_hi_B", {24'd0, n_B}, 32'h12);
        waitIdle();

        applyStimulus(2'b01, OP_REL, 16'h1005, 8'hF0);
        nextCycle();
        checkOutput("rel_hi_dec_ctl", {27'd0, n_add, n_inc, n_dec, n_pass, n_cin}, 32'b00100);
        waitIdle();
        applyStimulus(2'b11, OP_REL, 16'h10F0, 8'h20);
        waitIdle();
        applyStimulus(2'b11, OP_REL, 16'h1080, 8'h10);
        waitIdle();
        applyStimulus(2'b11, OP_REL, 16'h10F5, 8'hF0);
        waitIdle();

        // Fast path: the cycle after LO is DONE, with the ALU released.
        applyStimulus(2'b10, OP_ADD_IDX, 16'h1200, 8'h05);
        checkOutput("fast_lo_B", {24'd0, f_B}, 32'h00);
        nextCycle();
        checkOutput("fast_done_now", {31'd0, f_done}, 32'd1);
        checkOutput("fast_alu_zero", {11'd0, f_add, f_inc, f_dec, f_pass, f_cin, f_A, f_B}, 32'd0);
        waitIdle();

        // Ignored start in LO, then back-to-back start in DONE (normal instance).
        applyStimulus(2'b01, OP_INC16, 16'h00FF, 8'h00);
        op = OP_DEC16; base = 16'hAAAA; offset = 8'h55; start_v = 2'b01;
        nextCycle();
        start_v = 2'b00;
        nextCycle();
        checkOutput("b2b_in_done", {31'd0, n_done}, 32'd1);
        applyStimulus(2'b01, OP_REL, 16'h2080, 8'h90);
        checkOutput("b2b_lo_busy", {31'd0, n_busy}, 32'd1);
        checkOutput("b2b_lo_B", {24'd0, n_B}, 32'h80);
        waitIdle();

        // Back-to-back on the fast instance: a 2-cycle op followed by a crossing op.
        applyStimulus(2'b10, OP_ADD_IDX, 16'h3000, 8'h10);
        nextCycle();
        applyStimulus(2'b10, OP_INC16, 16'h30FF, 8'h00);
        waitIdle();

        // Reset during HI aborts the operation without a done pulse.
        applyStimulus(2'b01, OP_ADD_IDX, 16'h12F0, 8'h20);
        nextCycle();
        q0.delete();
        rst = 1'b1;
        nextCycle();
        checkOutput("abort_busy", {31'd0, n_busy}, 32'd0);
        checkOutput("abort_done", {31'd0, n_done}, 32'd0);
        checkOutput("abort_result", {n_result, f_result}, 32'd0);
        checkOutput("abort_alu", {11'd0, n_add, n_inc, n_dec, n_pass, n_cin, n_A, n_B}, 32'd0);
        rst = 1'b0;
        repeat (5) nextCycle();

        // Randomized operations, biased toward page boundaries.
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            rf = 8'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = rb;
                1: rb[7:0] = 8'hFF;
                2: rb[7:0] = 8'h00;
                default: rb = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
            endcase
            applyStimulus(2'b11, ro, rb, rf);
            waitIdle();
        end

        repeat (4) nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
